dds_sweep_scheduler: RTL and testbench

// - Sequences the phase-accumulator tuning word for automatic frequency sweeps.
// - Accepts one sweep profile (start, stop, step, dwell, mode) per handshake, then steps phase_m from start to stop, one update per dwell period.
// - Sits in the clk_1MHz domain between the control unit (profile source) and phase_accumulator (phase_m consumer).

---
 rtl/dds_pkg.sv | 18 +
 rtl/dds_dwell_timer.sv | 35 +++
 rtl/dds_sweep_scheduler.sv | 174 +++++++++++++++++
 tb/tb_dds_sweep_scheduler.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared widths, sweep mode codes and FSM state encoding for the DDS sweep scheduler.
package dds_pkg;

    localparam int M_W     = 13;
    localparam int DWELL_W = 16;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_LOOP   = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RUN_UP   = 2'b01,
        ST_RUN_DOWN = 2'b10,
        ST_HOLD_END = 2'b11
    } state_e;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable dwell down-counter; a zero load value is treated as one cycle.
// expire_o is high in the last cycle of a dwell period.
module dds_dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_val_i,
    output logic               expire_o
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    assign expire_o = en_i && (cnt_q == DWELL_W'(1));

    // next count: reload wins, otherwise count down while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (load_val_i == '0) ? DWELL_W'(1) : load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - DWELL_W'(1);
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/dds_sweep_scheduler.sv
// Steps the phase-accumulator tuning word from start to stop, one value per dwell period.
//
// state       | meaning
// ST_IDLE     | waiting for a profile, cfg_ready high
// ST_RUN_UP   | ascending by step, clamps to stop
// ST_RUN_DOWN | descending by step (triangle), clamps to start
// ST_HOLD_END | stop value held one dwell, then done / restart / turn around
module dds_sweep_scheduler
    import dds_pkg::*;
#(
    parameter int M_W     = dds_pkg::M_W,
    parameter int DWELL_W = dds_pkg::DWELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [M_W-1:0]     cfg_start_m,
    input  logic [M_W-1:0]     cfg_stop_m,
    input  logic [M_W-1:0]     cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    input  logic               abort,
    output logic [M_W-1:0]     phase_m,
    output logic               m_update,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic [M_W-1:0]     phase_q, phase_d;
    logic [M_W-1:0]     start_q, start_d;
    logic [M_W-1:0]     stop_q, stop_d;
    logic [M_W-1:0]     step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [1:0]         mode_q, mode_d;
    logic               m_update_q, m_update_d;
    logic               done_q, done_d;

    logic               accept;
    logic               expire;
    logic [M_W:0]       sum_up;
    logic [M_W:0]       diff_dn;
    logic [M_W:0]       diff_turn;

    assign accept    = cfg_valid && (state_q == ST_IDLE);
    // one extra bit so overflow past stop and borrow below zero are visible
    assign sum_up    = {1'b0, phase_q} + {1'b0, step_q};
    assign diff_dn   = {1'b0, phase_q} - {1'b0, step_q};
    assign diff_turn = {1'b0, stop_q}  - {1'b0, step_q};

    dds_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .en_i       (state_q != ST_IDLE),
        .load_i     (accept || expire),
        .load_val_i (accept ? cfg_dwell : dwell_q),
        .expire_o   (expire)
    );

    // next-state, profile capture and output pulse decode
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        start_d    = start_q;
        stop_d     = stop_q;
        step_d     = step_q;
        dwell_d    = dwell_q;
        mode_d     = mode_q;
        m_update_d = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    start_d    = cfg_start_m;
                    stop_d     = cfg_stop_m;
                    step_d     = (cfg_step == '0) ? M_W'(1) : cfg_step;
                    dwell_d    = cfg_dwell;
                    phase_d    = cfg_start_m;
                    m_update_d = 1'b1;
                    if (cfg_start_m >= cfg_stop_m) begin
                        // degenerate range: hold start once and finish, whatever the mode
                        mode_d  = MODE_SINGLE;
                        state_d = ST_HOLD_END;
                    end else begin
                        mode_d  = (cfg_mode == 2'b11) ? MODE_SINGLE : cfg_mode;
                        state_d = ST_RUN_UP;
                    end
                end
            end
            ST_RUN_UP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (expire) begin
                    m_update_d = 1'b1;
                    if (sum_up >= {1'b0, stop_q}) begin
                        phase_d = stop_q;
                        state_d = ST_HOLD_END;
                    end else begin
                        phase_d = sum_up[M_W-1:0];
                    end
                end
            end
            ST_RUN_DOWN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (expire) begin
                    m_update_d = 1'b1;
                    if (diff_dn[M_W] || (diff_dn[M_W-1:0] <= start_q)) begin
                        phase_d = start_q;
                        state_d = ST_RUN_UP;
                    end else begin
                        phase_d = diff_dn[M_W-1:0];
                    end
                end
            end
            ST_HOLD_END: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (expire) begin
                    if (mode_q == MODE_LOOP) begin
                        m_update_d = 1'b1;
                        phase_d    = start_q;
                        state_d    = ST_RUN_UP;
                    end else if (mode_q == MODE_TRI) begin
                        m_update_d = 1'b1;
                        if (diff_turn[M_W] || (diff_turn[M_W-1:0] <= start_q)) begin
                            phase_d = start_q;
                            state_d = ST_RUN_UP;
                        end else begin
                            phase_d = diff_turn[M_W-1:0];
                            state_d = ST_RUN_DOWN;
                        end
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            start_q    <= '0;
            stop_q     <= '0;
            step_q     <= '0;
            dwell_q    <= '0;
            mode_q     <= MODE_SINGLE;
            m_update_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            step_q     <= step_d;
            dwell_q    <= dwell_d;
            mode_q     <= mode_d;
            m_update_q <= m_update_d;
            done_q     <= done_d;
        end
    end

    assign phase_m   = phase_q;
    assign m_update  = m_update_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);
    assign cfg_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_dds_sweep_scheduler.sv
// Profile table drives the scheduler; expected per-cycle outputs are queued when a
// profile is offered and popped one per cycle as the DUT runs.
module tb_dds_sweep_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [12:0] cfg_start_m, cfg_stop_m, cfg_step;
    logic [15:0] cfg_dwell;
    logic [1:0]  cfg_mode;
    logic        abort;
    logic [12:0] phase_m;
    logic        m_update, busy, done;

    always #5 clk = ~clk;

    dds_sweep_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_start_m (cfg_start_m),
        .cfg_stop_m  (cfg_stop_m),
        .cfg_step    (cfg_step),
        .cfg_dwell   (cfg_dwell),
        .cfg_mode    (cfg_mode),
        .abort       (abort),
        .phase_m     (phase_m),
        .m_update    (m_update),
        .busy        (busy),
        .done        (done)
    );

    typedef struct packed {
        logic [12:0] phase;
        logic        upd;
        logic        busy;
        logic        done;
        logic        rdy;
    } exp_t;

    typedef struct {
        logic [12:0]       start;
        logic [12:0]       stop;
        logic [12:0]       step;
        logic [15:0]       dwell;
        logic [1:0]        mode;
        bit                ends_done;
        int                nvals;
        logic [23:0][12:0] vals;
    } vec_t;

    vec_t tbl[$];
    vec_t v;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input exp_t e);
        exp_t got;
        got = {phase_m, m_update, busy, done, cfg_ready};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got phase=%0d upd=%0b busy=%0b done=%0b rdy=%0b, want phase=%0d upd=%0b busy=%0b done=%0b rdy=%0b",
                     name, got.phase, got.upd, got.busy, got.done, got.rdy,
                     e.phase, e.upd, e.busy, e.done, e.rdy);
        end
    endtask

    task automatic new_vec(input logic [12:0] s, input logic [12:0] p, input logic [12:0] st,
                           input logic [15:0] d, input logic [1:0] m, input bit dn);
        v.start = s; v.stop = p; v.step = st; v.dwell = d; v.mode = m;
        v.ends_done = dn; v.nvals = 0; v.vals = '0;
    endtask

    task automatic add_val(input logic [12:0] x);
        v.vals[v.nvals] = x;
        v.nvals++;
    endtask

    // Offer one profile at the current negedge and check every following cycle.
    // Profiles that never finish are aborted in the first cycle of their last listed value.
    task automatic run_vec(input int idx);
        vec_t t;
        int   d;
        int   reps;
        exp_t e;
        string nm;
        t = tbl[idx];
        d = (t.dwell == 0) ? 1 : int'(t.dwell);
        for (int k = 0; k < t.nvals; k++) begin
            reps = (!t.ends_done && k == t.nvals - 1) ? 1 : d;
            for (int r = 0; r < reps; r++)
                sb.push_back({t.vals[k], (r == 0), 1'b1, 1'b0, 1'b0});
        end
        sb.push_back({t.vals[t.nvals-1], 1'b0, 1'b0, t.ends_done, 1'b1});

        nm = $sformatf("vec%0d_ready", idx);
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: got %0b want 1", nm, cfg_ready);
        end
        cfg_valid = 1'b1;
        cfg_start_m = t.start; cfg_stop_m = t.stop; cfg_step = t.step;
        cfg_dwell = t.dwell; cfg_mode = t.mode;
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int c = 0; sb.size() > 0; c++) begin
            e = sb.pop_front();
            check($sformatf("vec%0d_cyc%0d", idx, c), e);
            abort = (!t.ends_done && sb.size() == 1);
            if (sb.size() > 0) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; abort = 1'b0;
        cfg_start_m = '0; cfg_stop_m = '0; cfg_step = '0; cfg_dwell = '0; cfg_mode = '0;

        new_vec(13'd100, 13'd130, 13'd10, 16'd3, 2'b00, 1'b1);
        add_val(13'd100); add_val(13'd110); add_val(13'd120); add_val(13'd130);
        tbl.push_back(v);
        new_vec(13'd0, 13'd25, 13'd10, 16'd1, 2'b00, 1'b1);
        add_val(13'd0); add_val(13'd10); add_val(13'd20); add_val(13'd25);
        tbl.push_back(v);
        new_vec(13'd8000, 13'd8191, 13'd300, 16'd2, 2'b11, 1'b1);
        add_val(13'd8000); add_val(13'd8191);
        tbl.push_back(v);
        new_vec(13'd200, 13'd150, 13'd5, 16'd4, 2'b01, 1'b1);
        add_val(13'd200);
        tbl.push_back(v);
        new_vec(13'd100, 13'd130, 13'd10, 16'd2, 2'b10, 1'b0);
        add_val(13'd100); add_val(13'd110); add_val(13'd120); add_val(13'd130);
        add_val(13'd120); add_val(13'd110); add_val(13'd100); add_val(13'd110);
        add_val(13'd120);
        tbl.push_back(v);
        new_vec(13'd100, 13'd120, 13'd0, 16'd0, 2'b01, 1'b0);
        for (int k = 100; k <= 120; k++) add_val(13'(k));
        add_val(13'd100); add_val(13'd101);
        tbl.push_back(v);
        new_vec(13'd100, 13'd130, 13'd10, 16'd4, 2'b00, 1'b0);
        add_val(13'd100); add_val(13'd110); add_val(13'd120);
        tbl.push_back(v);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {13'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {13'd0, 1'b0, 1'b0, 1'b0, 1'b1});

        for (int i = 0; i < tbl.size(); i++) run_vec(i);

        // reset in the middle of a descending triangle leg; a stray profile offer while busy must be ignored
        cfg_valid = 1'b1;
        cfg_start_m = 13'd100; cfg_stop_m = 13'd130; cfg_step = 13'd10;
        cfg_dwell = 16'd2; cfg_mode = 2'b10;
        @(negedge clk);
        cfg_start_m = 13'd5; cfg_stop_m = 13'd9; cfg_step = 13'd1; cfg_dwell = 16'd1; cfg_mode = 2'b00;
        check("tri_first", {13'd100, 1'b1, 1'b1, 1'b0, 1'b0});
        repeat (8) @(negedge clk);
        check("tri_run_down_120", {13'd120, 1'b1, 1'b1, 1'b0, 1'b0});
        cfg_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_run_down", {13'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_mid_reset", {13'd0, 1'b0, 1'b0, 1'b0, 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
